otf_digit_collector: RTL and testbench

- Downstream stage of the online multiplier.
- Consumes the serial, MSD-first signed-digit product stream (`p`, with the `Out_vd`/`Out_rd` handshake on the multiplier side).
- Converts the stream on the fly into a conventional two's-complement word, with no carry-propagate addition.
- Presents the word through a valid/ready handshake once all `NDIG` digits of a frame have been absorbed.

---
 rtl/otf_digit_collector.sv | 152 +++++++++++++++
 tb/tb_otf_digit_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/otf_digit_collector.sv
// On-the-fly converter: MSD-first signed-digit stream to an NDIG+1 bit two's-complement word.
// Optional illegal-digit detection is enabled by defining OTF_ERR_CHECK_EN.
module otf_digit_collector #(
    parameter int NDIG = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                p,
    input  logic                      In_vd,
    output logic                      In_rd,
    output logic [NDIG:0]             q,
    output logic                      Out_vd,
    input  logic                      Out_rd,
    output logic [$clog2(NDIG+1)-1:0] dig_cnt,
    output logic                      dig_err
);

    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    function automatic logic digit_is_pos(input logic [1:0] d);
        return (d == 2'b10);
    endfunction

    function automatic logic digit_is_neg(input logic [1:0] d);
        return (d == 2'b01);
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [NDIG:0]     q_r;
    logic [NDIG:0]     q_s;
    logic [NDIG:0]     qm_r;
    logic [NDIG:0]     qm_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_s;
    logic              in_rd_r;
    logic              accept_s;
    logic              handshake_s;
    logic              last_s;

    assign accept_s    = In_vd && in_rd_r;
    assign handshake_s = (state_r == DONE) && Out_rd;
    assign last_s      = accept_s && (cnt_r == CW'(NDIG - 1));

    // Next-state logic: leave COLLECT on the final digit, leave DONE on the output handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            COLLECT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = COLLECT;
                end
            end
            DONE: begin
                if (handshake_s) begin
                    state_s = COLLECT;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = COLLECT;
        endcase
    end

    // Q/QM conversion step; keeping QM = Q-1 lets a negative digit select instead of subtract.
    always_comb begin
        q_s   = q_r;
        qm_s  = qm_r;
        cnt_s = cnt_r;
        if (handshake_s) begin
            q_s   = {(NDIG + 1){1'b0}};
            qm_s  = {(NDIG + 1){1'b1}};
            cnt_s = {CW{1'b0}};
        end else if (accept_s) begin
            cnt_s = cnt_r + CW'(1);
            if (digit_is_pos(p)) begin
                q_s  = {q_r[NDIG-1:0], 1'b1};
                qm_s = {q_r[NDIG-1:0], 1'b0};
            end else if (digit_is_neg(p)) begin
                q_s  = {qm_r[NDIG-1:0], 1'b1};
                qm_s = {qm_r[NDIG-1:0], 1'b0};
            end else begin
                q_s  = {q_r[NDIG-1:0], 1'b0};
                qm_s = {qm_r[NDIG-1:0], 1'b1};
            end
        end else begin
            q_s   = q_r;
            qm_s  = qm_r;
            cnt_s = cnt_r;
        end
    end

    // State and datapath registers; In_rd is registered so it stays low during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= COLLECT;
            q_r     <= {(NDIG + 1){1'b0}};
            qm_r    <= {(NDIG + 1){1'b1}};
            cnt_r   <= {CW{1'b0}};
            in_rd_r <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            qm_r    <= qm_s;
            cnt_r   <= cnt_s;
            in_rd_r <= (state_s == COLLECT);
        end
    end

`ifdef OTF_ERR_CHECK_EN
    logic err_r;
    logic err_s;

    // Sticky flag for an accepted 2'b11 digit, cleared at the next frame start.
    always_comb begin
        err_s = err_r;
        if (handshake_s) begin
            err_s = 1'b0;
        end else if (accept_s && (p == 2'b11)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end

    assign dig_err = err_r;
`else
    assign dig_err = 1'b0;
`endif

    assign q       = q_r;
    assign Out_vd  = (state_r == DONE);
    assign In_rd   = in_rd_r;
    assign dig_cnt = cnt_r;

endmodule

// File: tb/tb_otf_digit_collector.sv
// Directed bench for otf_digit_collector with NDIG=8; expected words are hand-computed.
module tb_otf_digit_collector;

    localparam int NDIG = 8;

    logic       clk;
    logic       rst;
    logic [1:0] p;
    logic       In_vd;
    logic       In_rd;
    logic [8:0] q;
    logic       Out_vd;
    logic       Out_rd;
    logic [3:0] dig_cnt;
    logic       dig_err;

    int n_cmp = 0;
    int n_err = 0;

    otf_digit_collector #(.NDIG(NDIG)) dut (
        .clk(clk), .rst(rst), .p(p), .In_vd(In_vd), .In_rd(In_rd),
        .q(q), .Out_vd(Out_vd), .Out_rd(Out_rd), .dig_cnt(dig_cnt), .dig_err(dig_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int d);
        if (d > 1) return 2'b11;
        if (d == 1) return 2'b10;
        if (d == -1) return 2'b01;
        return 2'b00;
    endfunction

    // present one digit and wait (bounded) for it to be accepted
    task automatic send(input int d);
        int guard;
        guard = 0;
        p = enc(d);
        In_vd = 1'b1;
        while (!In_rd && guard < 20) begin
            tick();
            guard++;
        end
        if (!In_rd) chk("send_timeout", 32'd0, 32'd1);
        tick();
        In_vd = 1'b0;
    endtask

    task automatic send_frame(input int d0, d1, d2, d3, d4, d5, d6, d7);
        send(d0); send(d1); send(d2); send(d3);
        send(d4); send(d5); send(d6); send(d7);
    endtask

    task automatic finish_frame(input string tag, input logic [8:0] exp_q);
        chk({tag, "_vd"}, Out_vd, 1'b1);
        chk({tag, "_q"}, q, exp_q);
        chk({tag, "_cnt"}, dig_cnt, 4'd8);
        Out_rd = 1'b1;
        tick();
        chk({tag, "_rel"}, Out_vd, 1'b0);
    endtask

    initial begin
        rst = 1'b1; p = 2'b00; In_vd = 1'b0; Out_rd = 1'b0;
        tick(); tick();
        chk("rst_in_rd", In_rd, 1'b0);
        chk("rst_out_vd", Out_vd, 1'b0);
        chk("rst_q", q, 9'h000);
        chk("rst_cnt", dig_cnt, 4'd0);
        chk("rst_err", dig_err, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_rd", In_rd, 1'b1);

        // 1: eight +1 with Out_rd already high
        Out_rd = 1'b1;
        send_frame(1, 1, 1, 1, 1, 1, 1, 1);
        chk("t1_vd", Out_vd, 1'b1);
        chk("t1_q", q, 9'h0FF);
        chk("t1_cnt", dig_cnt, 4'd8);
        chk("t1_in_rd_low", In_rd, 1'b0);
        tick();
        chk("t1_vd_pulse", Out_vd, 1'b0);
        chk("t1_in_rd_back", In_rd, 1'b1);
        chk("t1_cnt_clr", dig_cnt, 4'd0);

        // 2: negative and mixed frames
        send_frame(-1, -1, -1, -1, -1, -1, -1, -1);
        finish_frame("t2a", 9'h101);
        send_frame(1, -1, -1, -1, -1, -1, -1, -1);
        finish_frame("t2b", 9'h001);
        send_frame(0, 1, -1, 0, 0, 0, 0, 1);
        finish_frame("t2c", 9'h021);

        // 3: back-pressure with the producer still offering digits
        Out_rd = 1'b0;
        send_frame(1, 0, 1, 0, 1, 0, 1, 0);
        p = enc(1); In_vd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_q", q, 9'h0AA);
            chk("t3_vd", Out_vd, 1'b1);
            chk("t3_in_rd", In_rd, 1'b0);
            chk("t3_cnt", dig_cnt, 4'd8);
        end
        Out_rd = 1'b1;
        tick();
        chk("t3_rel_vd", Out_vd, 1'b0);
        chk("t3_rel_in_rd", In_rd, 1'b1);
        chk("t3_rel_cnt", dig_cnt, 4'd0);
        tick();
        chk("t3_first_cnt", dig_cnt, 4'd1);
        chk("t3_first_q", q, 9'h001);
        In_vd = 1'b0;

        // 5: reset after three accepted +1 digits, then a zero frame
        send(1); send(1);
        chk("t5_cnt3", dig_cnt, 4'd3);
        chk("t5_q3", q, 9'h007);
        chk("t5_no_vd", Out_vd, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_q", q, 9'h000);
        chk("t5_rst_cnt", dig_cnt, 4'd0);
        chk("t5_rst_in_rd", In_rd, 1'b0);
        chk("t5_rst_vd", Out_vd, 1'b0);
        tick();
        chk("t5_in_rd_up", In_rd, 1'b1);
        send_frame(0, 0, 0, 0, 0, 0, 0, 0);
        finish_frame("t5", 9'h000);

        // 4: producer bubbles, digits +1,-1,0,+1,+1,0,-1,+1 = 87
        Out_rd = 1'b0;
        begin
            int ds[8];
            ds = '{1, -1, 0, 1, 1, 0, -1, 1};
            for (int i = 0; i < 8; i++) begin
                p = enc(ds[i]); In_vd = 1'b1;
                tick();
                chk("t4_cnt_acc", dig_cnt, 32'(i + 1));
                if (i < 7) begin
                    p = enc(-1); In_vd = 1'b0;
                    tick();
                    chk("t4_cnt_gap", dig_cnt, 32'(i + 1));
                    chk("t4_gap_vd", Out_vd, 1'b0);
                end
            end
            In_vd = 1'b0;
        end
        finish_frame("t4", 9'h057);

        // 6: illegal digit at position 4 counts as zero
        Out_rd = 1'b0;
        send_frame(1, 1, 1, 3, 1, 1, 1, 1);
        chk("t6_q", q, 9'h0EF);
`ifdef OTF_ERR_CHECK_EN
        chk("t6_err", dig_err, 1'b1);
`else
        chk("t6_err", dig_err, 1'b0);
`endif
        finish_frame("t6", 9'h0EF);
        chk("t6_err_clr", dig_err, 1'b0);
        chk("t6_cnt_clr", dig_cnt, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
